// File: rtl/cardinal_nic.sv
// cardinal_nic: one-entry output/input channel buffers between a cardinal processor and its ring router.
// Define CARDINAL_NIC_PKTCNT_EN to add saturating sent/recv packet counters to the status words.
module cardinal_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_BIT     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di
);
  localparam logic [1:0] A_IN_BUF  = 2'b00;
  localparam logic [1:0] A_IN_ST   = 2'b01;
  localparam logic [1:0] A_OUT_BUF = 2'b10;
  localparam logic [1:0] A_OUT_ST  = 2'b11;

  logic [0:DATA_WIDTH-1] in_buf, out_buf, in_st, out_st;
  logic                  in_full, out_full;
  logic                  rd, wr, drain, accept;

  assign rd     = nicEn & ~nicWrEn;
  assign wr     = nicEn & nicWrEn;
  assign drain  = rd & (addr == A_IN_BUF) & in_full;
  assign accept = net_si & ~in_full;

  // Injection only in the ring cycle whose polarity matches the packet's VC bit.
  assign net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
  assign net_do = out_buf;
  assign net_ri = ~in_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
      in_buf   <= '0;
      in_full  <= 1'b0;
    end else begin
      // A write racing an injection sees out_full=1 and is dropped.
      if (net_so)
        out_full <= 1'b0;
      else if (wr && addr == A_OUT_BUF && !out_full) begin
        out_buf  <= d_in;
        out_full <= 1'b1;
      end
      if (drain)
        in_full <= 1'b0;
      else if (accept) begin
        in_buf  <= net_di;
        in_full <= 1'b1;
      end
    end
  end

`ifdef CARDINAL_NIC_PKTCNT_EN
  logic [15:0] sent_cnt, recv_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_cnt <= '0;
      recv_cnt <= '0;
    end else begin
      if (net_so && sent_cnt != 16'hFFFF) sent_cnt <= sent_cnt + 16'd1;
      if (accept && recv_cnt != 16'hFFFF) recv_cnt <= recv_cnt + 16'd1;
    end
  end
`endif

  always_comb begin
    in_st  = '0;
    out_st = '0;
    in_st[DATA_WIDTH-1]  = in_full;
    out_st[DATA_WIDTH-1] = out_full;
`ifdef CARDINAL_NIC_PKTCNT_EN
    in_st[0:15]  = recv_cnt;
    out_st[0:15] = sent_cnt;
`endif
    d_out = '0;
    if (rd) begin
      case (addr)
        A_IN_BUF:  d_out = in_buf;
        A_IN_ST:   d_out = in_st;
        A_OUT_BUF: d_out = out_buf;
        A_OUT_ST:  d_out = out_st;
        default:   d_out = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_cardinal_nic.sv
// Bench for cardinal_nic: directed scenarios plus random traffic against a queue-based channel model.
module tb_cardinal_nic;
  localparam int DW     = 64;
  localparam int VC_BIT = 0;

  logic          clk = 1'b0, reset = 1'b1;
  logic [1:0]    addr = '0;
  logic [DW-1:0] d_in = '0, d_out, net_do, net_di = '0;
  logic          nicEn = 1'b0, nicWrEn = 1'b0, net_so, net_ro = 1'b0;
  logic          net_polarity = 1'b0, net_si = 1'b0, net_ri;

  int checks = 0, errors = 0;

  // Model: each channel is a queue holding at most one packet, plus the last data ever stored.
  logic [DW-1:0] oq[$], iq[$];
  logic [DW-1:0] out_val = '0, in_val = '0;
  int            sent = 0, recv = 0;

  logic [DW-1:0] obs_dout, obs_do;
  logic          obs_so, obs_ri;

  always #5 clk = ~clk;

  cardinal_nic #(.DATA_WIDTH(DW), .VC_BIT(VC_BIT)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
    .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] status(input bit full, input int cnt);
    logic [DW-1:0] s;
    s = '0;
    s[0] = full;
`ifdef CARDINAL_NIC_PKTCNT_EN
    s[DW-1 -: 16] = cnt[15:0];
`endif
    return s;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance the model for the coming edge.
  task automatic step(input logic en, input logic wr, input logic [1:0] a, input logic [DW-1:0] din,
                      input logic ro, input logic pol, input logic si, input logic [DW-1:0] di);
    logic          exp_so;
    logic [DW-1:0] exp_dout;
    nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_ro = ro; net_polarity = pol; net_si = si; net_di = di;
    @(negedge clk);
    exp_so = 1'b0;
    if (oq.size() > 0) exp_so = ro && (oq[0][DW-1-VC_BIT] == pol);
    exp_dout = '0;
    if (en && !wr) begin
      case (a)
        2'd0: exp_dout = in_val;
        2'd1: exp_dout = status(iq.size() > 0, recv);
        2'd2: exp_dout = out_val;
        default: exp_dout = status(oq.size() > 0, sent);
      endcase
    end
    obs_so = net_so; obs_ri = net_ri; obs_dout = d_out; obs_do = net_do;
    chk("net_so", {63'b0, net_so}, {63'b0, exp_so});
    chk("net_ri", {63'b0, net_ri}, {63'b0, iq.size() == 0});
    chk("net_do", net_do, out_val);
    if (!(en && wr)) chk("d_out", d_out, exp_dout);
    if (exp_so) begin
      void'(oq.pop_front());
      sent = sat_inc(sent);
    end else if (en && wr && a == 2'd2 && oq.size() == 0) begin
      oq.push_back(din);
      out_val = din;
    end
    if (en && !wr && a == 2'd0 && iq.size() > 0)
      void'(iq.pop_front());
    else if (si && iq.size() == 0) begin
      iq.push_back(di);
      in_val = di;
      recv = sat_inc(recv);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    oq.delete(); iq.delete();
    out_val = '0; in_val = '0; sent = 0; recv = 0;
  endtask

  initial begin
    #2;
    chk("rst_so", {63'b0, net_so}, 64'd0);
    chk("rst_ri", {63'b0, net_ri}, 64'd1);
    chk("rst_do", net_do, 64'd0);
    chk("rst_dout", d_out, 64'd0);
    nicEn = 1'b1; addr = 2'd1; #1 chk("rst_in_st", d_out, 64'd0);
    addr = 2'd3; #1 chk("rst_out_st", d_out, 64'd0);
    nicEn = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    // Injection waits for the polarity-0 cycle.
    step(1, 1, 2'd2, 64'h0123_4567_89AB_CDEF, 1, 0, 0, '0);
    chk("inj_empty_so", {63'b0, obs_so}, 64'd0);
    step(0, 0, 2'd0, '0, 1, 1, 0, '0);
    chk("inj_pol1_so", {63'b0, obs_so}, 64'd0);
    step(0, 0, 2'd0, '0, 1, 0, 0, '0);
    chk("inj_pol0_so", {63'b0, obs_so}, 64'd1);
    chk("inj_do", obs_do, 64'h0123_4567_89AB_CDEF);
    step(1, 0, 2'd3, '0, 1, 0, 0, '0);
`ifndef CARDINAL_NIC_PKTCNT_EN
    chk("inj_out_st", obs_dout, 64'd0);
`endif

    // Write to a full output buffer is dropped.
    step(1, 1, 2'd2, 64'h1111, 0, 0, 0, '0);
    step(1, 1, 2'd2, 64'hDEAD, 0, 0, 0, '0);
    step(1, 0, 2'd2, '0, 0, 0, 0, '0);
    chk("full_wr_buf", obs_dout, 64'h1111);
    step(1, 0, 2'd3, '0, 0, 0, 0, '0);
`ifndef CARDINAL_NIC_PKTCNT_EN
    chk("full_out_st", obs_dout, 64'd1);
`endif

    // Ejection and processor drain.
    step(0, 0, 2'd0, '0, 0, 0, 1, 64'hCAFE);
    step(1, 0, 2'd1, '0, 0, 0, 0, '0);
    chk("ej_ri_low", {63'b0, obs_ri}, 64'd0);
`ifndef CARDINAL_NIC_PKTCNT_EN
    chk("ej_in_st", obs_dout, 64'd1);
`endif
    step(1, 0, 2'd0, '0, 0, 0, 0, '0);
    chk("ej_in_buf", obs_dout, 64'hCAFE);
    step(1, 0, 2'd1, '0, 0, 0, 0, '0);
    chk("ej_ri_high", {63'b0, obs_ri}, 64'd1);
`ifndef CARDINAL_NIC_PKTCNT_EN
    chk("ej_in_st_clr", obs_dout, 64'd0);
`endif

    // Reset with both buffers full and an injection ready.
    step(0, 0, 2'd0, '0, 0, 0, 1, 64'hF00D);
    nicEn = 1'b0; net_si = 1'b0; net_ro = 1'b1; net_polarity = 1'b0;
    #1 chk("pre_rst_so", {63'b0, net_so}, 64'd1);
    reset = 1'b1;
    #1 chk("mid_rst_so", {63'b0, net_so}, 64'd0);
    chk("mid_rst_ri", {63'b0, net_ri}, 64'd1);
    nicEn = 1'b1; addr = 2'd1; #1 chk("mid_rst_in_st", d_out, 64'd0);
    addr = 2'd3; #1 chk("mid_rst_out_st", d_out, 64'd0);
    nicEn = 1'b0;
    model_reset();
    @(posedge clk); #1 reset = 1'b0;

`ifdef CARDINAL_NIC_PKTCNT_EN
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2'd2, 64'h10 + 64'(i), 0, 0, 0, '0);
      step(0, 0, 2'd0, '0, 1, 0, 0, '0);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 2'd0, '0, 0, 0, 1, 64'h20 + 64'(i));
      step(1, 0, 2'd0, '0, 0, 0, 0, '0);
    end
    step(1, 0, 2'd3, '0, 0, 0, 0, '0);
    chk("cnt_sent", obs_dout, 64'h0003_0000_0000_0000);
    step(1, 0, 2'd1, '0, 0, 0, 0, '0);
    chk("cnt_recv", obs_dout, 64'h0002_0000_0000_0000);
`endif

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
           {$urandom, $urandom}, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 2) == 0), {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cardinal_nic.md
# cardinal_nic

Network interface controller sitting between one cardinal processor's NIC port and its ring router. It holds a one-entry output channel buffer the processor fills, which is injected into the router under the ring's polarity rule. It also holds a one-entry input channel buffer the router fills, which the processor drains. Four instances, one per node, connect the processor array to the ring.

## Interface
Parameters:
- DATA_WIDTH, 64, packet/data word width; bit 0 is the MSB in [0:DATA_WIDTH-1] ordering.
- VC_BIT, 0, index of the packet's virtual-channel bit compared against net_polarity.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- addr  in  2  processor register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  in  DATA_WIDTH  processor write data.
- d_out  out  DATA_WIDTH  processor read data.
- nicEn  in  1  processor access enable.
- nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn.
- net_so  out  1  send-out strobe to router.
- net_ro  in  1  router ready to accept from NIC.
- net_do  out  DATA_WIDTH  packet to router.
- net_polarity  in  1  router's current even/odd cycle polarity.
- net_si  in  1  send-in strobe from router.
- net_ri  out  1  NIC ready to accept from router.
- net_di  in  DATA_WIDTH  packet from router.

## Operation
- State:
  - in_buf/in_full: input channel buffer.
  - out_buf/out_full: output channel buffer.
- Processor write (nicEn=1, nicWrEn=1):
  - addr 10 with out_full=0: out_buf<=d_in, out_full<=1.
  - addr 10 with out_full=1: ignored, no error flag.
  - addr 00, 01, 11: ignored.
- Processor read (nicEn=1, nicWrEn=0), combinational d_out:
  - 00: in_buf.
  - 01: status word, all zero except LSB (bit DATA_WIDTH-1) = in_full.
  - 10: out_buf.
  - 11: status word, LSB = out_full.
  - nicEn=0: d_out=0.
- Read of addr 00 with in_full=1 clears in_full at the clock edge. Read with in_full=0 returns stale in_buf and changes nothing.
- Injection:
  - net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity).
  - net_do = out_buf at all times.
  - When net_so=1, out_full<=0 at the edge.
- Ejection:
  - net_ri = ~in_full.
  - When net_si=1 and in_full=0: in_buf<=net_di, in_full<=1.
  - net_si while in_full=1 is a router protocol violation; the data is dropped and in_full stays 1.
- Simultaneous events:
  - A processor write to 10 in the same cycle net_so=1 is ignored, because out_full is still 1 in that cycle.
  - Router arrival and processor drain cannot coincide, since arrival requires empty and drain requires full.

## Timing
- Reset values:
  - Outputs: d_out=0, net_so=0, net_do=0, net_ri=1.
  - State: in_full=0, out_full=0, in_buf=0, out_buf=0.
- Processor write to 10 sets out_full at the following edge. Earliest net_so is the next cycle, when polarity matches.
- Worst-case injection wait is one extra cycle for polarity alignment while net_ro=1.
- A packet accepted at edge N is readable at addr 00 in cycle N+1. net_ri drops in cycle N+1 and returns high in the cycle after the draining read edge.
- Reset asserted mid-operation discards both buffers. No partial packet is sent.
- net_so and net_ri are combinational from registered state and router inputs. There is no combinational path from net_di to net_ri.

## Configuration
- CARDINAL_NIC_PKTCNT_EN defined:
  - Adds two 16-bit saturating counters, sent_cnt (incremented on each net_so) and recv_cnt (incremented on each accepted net_si). Both reset to 0.
  - Status reads return the counter in bits [0:15]: addr 01 returns recv_cnt, addr 11 returns sent_cnt. The LSB still carries the full flag.
  - Counters saturate at 16'hFFFF and do not wrap.
- Undefined: counters are absent and status bits [0:DATA_WIDTH-2] read 0.

## Test plan
- Reset then read addr 01 and 11 -> d_out=64'h0 both. net_ri=1, net_so=0.
- Write 64'h0123_4567_89AB_CDEF to addr 10 (VC bit 0), net_ro=1, polarity toggling from 1 -> net_so=1 only in the polarity-0 cycle, net_do=written value. Addr 11 then reads 0.
- Fill out_buf, hold net_ro=0, write 64'hDEAD to addr 10 -> write ignored, out_buf unchanged. Addr 11 reads 64'h1.
- net_si=1 with net_di=64'hCAFE -> net_ri=0 next cycle; addr 01 reads 1; addr 00 reads 64'hCAFE; after that read, net_ri=1 and addr 01 reads 0.
- Assert reset while both buffers are full and net_ro=1 -> net_so=0 immediately, net_ri=1, both status reads return 0.
- With CARDINAL_NIC_PKTCNT_EN, send 3 packets and receive 2 -> addr 11 reads 64'h0003_0000_0000_0000 (| full flag); addr 01 reads 64'h0002_0000_0000_0000.
